// File: rtl/issue_sequencer.sv
// Instruction FIFO feeding a five-state issue FSM (IDLE/DEC/OPR/EXE/WB).
// Latency: word pushed at edge E0 into an idle, empty block is in DEC from E1;
//          a 4-cycle instruction retires in the cycle after E4, a NOP in the
//          DEC cycle right after its pop edge.
// Backpressure: in_ready = (fifo_count != DEPTH), combinational; a full FIFO
//          refuses a push even on an edge where a pop frees a slot.
//
// Ports (issue_sequencer):
//   clk, rst_n              single clock, asynchronous active-low reset
//   in_valid, in_inst       fetch side, 32-bit instruction word (opcode [6:0])
//   in_ready                FIFO not full
//   flush                   synchronous abort of queue and in-flight instruction
//   issue_inst              instruction held for the control FSM (registered)
//   busy, phase             in-flight flag and Gray phase 00/01/11/10 (registered)
//   retire, illegal         one-cycle completion / drop pulses (registered)
//   fifo_count              queued entries, excluding the in-flight instruction
//
// sync_fifo is the generic storage queue used by the sequencer. DEPTH must be
// a power of two (pointers wrap by natural overflow) and at least 2.

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,     // empties the queue, blocks push/pop
  input  logic                   wr_vld,
  input  logic [WIDTH-1:0]       wr_dat,
  output logic                   wr_rdy,
  input  logic                   rd_rdy,  // pop request
  output logic                   rd_vld,
  output logic [WIDTH-1:0]       rd_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push;
  logic             pop;

  // wr_rdy looks only at the registered count, so a full queue cannot be
  // written on the same edge that pops it.
  assign wr_rdy = (count_q != FULL_CNT);
  assign rd_vld = (count_q != '0);
  assign rd_dat = mem_q[rd_ptr_q];
  assign count  = count_q;

  always_comb begin
    push     = wr_vld && wr_rdy && !clr;
    pop      = rd_rdy && rd_vld && !clr;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_dat;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

module issue_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [31:0]            in_inst,
  output logic                   in_ready,
  input  logic                   flush,
  output logic [31:0]            issue_inst,
  output logic                   busy,
  output logic [1:0]             phase,
  output logic                   retire,
  output logic                   illegal,
  output logic [$clog2(DEPTH):0] fifo_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DEC  = 3'd1,
    S_OPR  = 3'd2,
    S_EXE  = 3'd3,
    S_WB   = 3'd4
  } state_e;

  // Phase codes form a Gray sequence so a consumer sees one bit flip per step.
  localparam logic [1:0] PH_DEC = 2'b00;
  localparam logic [1:0] PH_OPR = 2'b01;
  localparam logic [1:0] PH_EXE = 2'b11;
  localparam logic [1:0] PH_WB  = 2'b10;

  localparam logic [6:0] OP_NOP = 7'h00;

  function automatic logic op_is_legal(input logic [6:0] op);
    case (op)
      7'h00, 7'h01, 7'h02, 7'h04,
      7'h05, 7'h08, 7'h09, 7'h37: op_is_legal = 1'b1;
      default:                    op_is_legal = 1'b0;
    endcase
  endfunction

  // NOPs and dropped (illegal) opcodes finish in their DEC cycle.
  function automatic logic op_is_single_cycle(input logic [6:0] op);
    op_is_single_cycle = (op == OP_NOP) || !op_is_legal(op);
  endfunction

  state_e      state_q, state_d;
  logic [31:0] issue_inst_q, issue_inst_d;
  logic        busy_q, busy_d;
  logic [1:0]  phase_q, phase_d;
  logic        retire_q, retire_d;
  logic        illegal_q, illegal_d;

  logic        pop;
  logic        instr_done;
  logic        head_vld;
  logic [31:0] head_dat;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (flush),
    .wr_vld (in_valid),
    .wr_dat (in_inst),
    .wr_rdy (in_ready),
    .rd_rdy (pop),
    .rd_vld (head_vld),
    .rd_dat (head_dat),
    .count  (fifo_count)
  );

  always_comb begin
    state_d      = state_q;
    issue_inst_d = issue_inst_q;
    pop          = 1'b0;
    instr_done   = 1'b0;
    busy_d       = 1'b0;
    phase_d      = PH_DEC;
    retire_d     = 1'b0;
    illegal_d    = 1'b0;

    // IDLE behaves like "previous instruction finished" so the pop path
    // below serves both the first issue and back-to-back issue.
    case (state_q)
      S_IDLE: instr_done = 1'b1;
      S_DEC: begin
        if (op_is_single_cycle(issue_inst_q[6:0])) begin
          instr_done = 1'b1;
        end else begin
          state_d = S_OPR;
        end
      end
      S_OPR:   state_d    = S_EXE;
      S_EXE:   state_d    = S_WB;
      S_WB:    instr_done = 1'b1;
      default: state_d    = S_IDLE;
    endcase

    if (instr_done) begin
      if (head_vld) begin
        pop          = 1'b1;
        issue_inst_d = head_dat;
        state_d      = S_DEC;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Flush wins over everything: no pop, no advance, no pulses.
    if (flush) begin
      state_d      = S_IDLE;
      pop          = 1'b0;
      issue_inst_d = issue_inst_q;
    end

    // Outputs are registered, so they are decoded from the state being
    // entered. DEC is only ever entered through a pop, so issue_inst_d holds
    // the word whose DEC cycle this is.
    case (state_d)
      S_DEC: begin
        busy_d    = 1'b1;
        phase_d   = PH_DEC;
        retire_d  = (issue_inst_d[6:0] == OP_NOP);
        illegal_d = !op_is_legal(issue_inst_d[6:0]);
      end
      S_OPR: begin
        busy_d  = 1'b1;
        phase_d = PH_OPR;
      end
      S_EXE: begin
        busy_d  = 1'b1;
        phase_d = PH_EXE;
      end
      S_WB: begin
        busy_d   = 1'b1;
        phase_d  = PH_WB;
        retire_d = 1'b1;
      end
      default: begin
        busy_d  = 1'b0;
        phase_d = PH_DEC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      issue_inst_q <= '0;
      busy_q       <= 1'b0;
      phase_q      <= PH_DEC;
      retire_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_inst_q <= issue_inst_d;
      busy_q       <= busy_d;
      phase_q      <= phase_d;
      retire_q     <= retire_d;
      illegal_q    <= illegal_d;
    end
  end

  assign issue_inst = issue_inst_q;
  assign busy       = busy_q;
  assign phase      = phase_q;
  assign retire     = retire_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_issue_sequencer.sv
// Bench for issue_sequencer: directed scenarios plus randomized traffic,
// checked against a queue-based transaction model.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.

module tb_issue_sequencer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b1;
  logic          in_valid = 1'b0;
  logic [31:0]   in_inst  = 32'h0;
  logic          flush    = 1'b0;
  logic          in_ready;
  logic [31:0]   issue_inst;
  logic          busy;
  logic [1:0]    phase;
  logic          retire;
  logic          illegal;
  logic [CW-1:0] fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  issue_sequencer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_ready   (in_ready),
    .flush      (flush),
    .issue_inst (issue_inst),
    .busy       (busy),
    .phase      (phase),
    .retire     (retire),
    .illegal    (illegal),
    .fifo_count (fifo_count)
  );

  // ---------------- reference model (transaction level) ----------------
  logic [6:0]  legal_ops [8] = '{7'h00, 7'h01, 7'h02, 7'h04, 7'h05, 7'h08, 7'h09, 7'h37};
  logic [1:0]  gray_tbl  [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  logic [31:0] mq [$];
  bit          m_active = 1'b0;
  logic [31:0] m_word   = 32'h0;
  int          m_pos    = 0;
  bit          last_acc = 1'b0;

  function automatic bit op_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int m_len();
    if (m_word[6:0] == 7'h00 || !op_legal(m_word[6:0])) return 1;
    return 4;
  endfunction

  function automatic logic [1:0] m_phase();
    if (!m_active) return 2'b00;
    return gray_tbl[m_pos];
  endfunction

  function automatic logic m_retire();
    return m_active && op_legal(m_word[6:0]) && (m_pos == m_len() - 1);
  endfunction

  function automatic logic m_illegal();
    return m_active && !op_legal(m_word[6:0]);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_active = 1'b0;
    m_word   = 32'h0;
    m_pos    = 0;
  endtask

  task automatic model_step(input logic v, input logic [31:0] w, input logic f);
    bit          done;
    bit          do_pop;
    bit          do_push;
    int          sz;
    logic [31:0] head;
    last_acc = 1'b0;
    head     = 32'h0;
    if (f) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      return;
    end
    sz      = mq.size();
    done    = !m_active || (m_pos == m_len() - 1);
    do_pop  = done && (sz > 0);
    do_push = v && (sz != DEPTH);
    if (do_pop) head = mq.pop_front();
    if (do_push) mq.push_back(w);
    last_acc = do_push;
    if (do_pop) begin
      m_active = 1'b1;
      m_word   = head;
      m_pos    = 0;
    end else if (done) begin
      m_active = 1'b0;
    end else begin
      m_pos++;
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 unit after the edge.
  task automatic tick(input logic v, input logic [31:0] w, input logic f);
    in_valid = v;
    in_inst  = w;
    flush    = f;
    model_step(v, w, f);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic go_idle();
    tick(1'b0, 32'h0, 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL reset_phase got=%b exp=00", phase); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL reset_retire got=%b exp=0", retire); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (issue_inst !== 32'h0) begin errors++; $display("FAIL reset_issue got=%h exp=0", issue_inst); end
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b1, 32'h0000_0001, 1'b0);
    checks++; if (fifo_count !== CW'(1)) begin errors++; $display("FAIL first_push_count got=%0d exp=1", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_push_busy got=%b exp=0", busy); end
  endtask

  task automatic test_four_cycle();
    logic [1:0] ph [4];
    ph = '{2'b00, 2'b01, 2'b11, 2'b10};
    go_idle();
    tick(1'b1, 32'h0000_0002, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL four_idle_busy got=%b exp=0", busy); end
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 32'h0, 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL four_busy c=%0d got=%b exp=1", c, busy); end
      checks++; if (phase !== ph[c]) begin errors++; $display("FAIL four_phase c=%0d got=%b exp=%b", c, phase, ph[c]); end
      checks++; if (retire !== (c == 3)) begin errors++; $display("FAIL four_retire c=%0d got=%b exp=%b", c, retire, (c == 3)); end
      checks++; if (issue_inst !== 32'h2) begin errors++; $display("FAIL four_issue c=%0d got=%h exp=2", c, issue_inst); end
    end
    tick(1'b0, 32'h0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL four_done_busy got=%b exp=0", busy); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL four_done_retire got=%b exp=0", retire); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w  [3];
    logic [31:0] ei [10];
    logic [1:0]  ep [10];
    logic        er [10];
    w  = '{32'h2, 32'h0, 32'h4};
    ei = '{32'h2, 32'h2, 32'h2, 32'h2, 32'h0, 32'h4, 32'h4, 32'h4, 32'h4, 32'h4};
    ep = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    er = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    go_idle();
    tick(1'b1, w[0], 1'b0);
    for (int c = 0; c < 10; c++) begin
      if (c < 2) tick(1'b1, w[c+1], 1'b0);
      else       tick(1'b0, 32'h0, 1'b0);
      checks++; if (busy !== (c < 9)) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", c + 1, busy, (c < 9)); end
      checks++; if (phase !== ep[c]) begin errors++; $display("FAIL b2b_phase cyc=%0d got=%b exp=%b", c + 1, phase, ep[c]); end
      checks++; if (retire !== er[c]) begin errors++; $display("FAIL b2b_retire cyc=%0d got=%b exp=%b", c + 1, retire, er[c]); end
      if (c < 9) begin
        checks++; if (issue_inst !== ei[c]) begin errors++; $display("FAIL b2b_issue cyc=%0d got=%h exp=%h", c + 1, issue_inst, ei[c]); end
      end
    end
  endtask

  task automatic test_nop_stream();
    go_idle();
    tick(1'b1, 32'h0000_0080, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick(c < 5, (32'(c + 2) << 7), 1'b0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nop_busy c=%0d got=%b exp=1", c, busy); end
      checks++; if (retire !== 1'b1) begin errors++; $display("FAIL nop_retire c=%0d got=%b exp=1", c, retire); end
      checks++; if (phase !== 2'b00) begin errors++; $display("FAIL nop_phase c=%0d got=%b exp=00", c, phase); end
      checks++; if (issue_inst !== (32'(c + 1) << 7)) begin errors++; $display("FAIL nop_issue c=%0d got=%h exp=%h", c, issue_inst, (32'(c + 1) << 7)); end
    end
    tick(1'b0, 32'h0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nop_end_busy got=%b exp=0", busy); end
  endtask

  task automatic test_illegal();
    go_idle();
    tick(1'b1, 32'h0000_007F, 1'b0);
    tick(1'b0, 32'h0, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ill_busy got=%b exp=1", busy); end
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL ill_phase got=%b exp=00", phase); end
    checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_pulse got=%b exp=1", illegal); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL ill_retire got=%b exp=0", retire); end
    checks++; if (issue_inst !== 32'h7F) begin errors++; $display("FAIL ill_issue got=%h exp=7f", issue_inst); end
    tick(1'b0, 32'h0, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ill_after_busy got=%b exp=0", busy); end
    checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_after_pulse got=%b exp=0", illegal); end
  endtask

  task automatic test_backpressure();
    logic [31:0] sent [$];
    logic [31:0] got  [$];
    logic [31:0] w;
    int k;
    bit saw_full;
    bit saw_reopen;
    k = 0;
    saw_full = 1'b0;
    saw_reopen = 1'b0;
    go_idle();
    for (int c = 0; c < 40; c++) begin
      w = (32'(k) << 7) | 32'h09;
      tick(1'b1, w, 1'b0);
      if (last_acc) begin sent.push_back(w); k++; end
      if (retire === 1'b1) got.push_back(issue_inst);
      checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL bp_count c=%0d got=%0d exp=%0d", c, fifo_count, mq.size()); end
      if (fifo_count === FULL_CNT) begin
        saw_full = 1'b1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full c=%0d got=%b exp=0", c, in_ready); end
      end else if (saw_full && in_ready === 1'b1) begin
        saw_reopen = 1'b1;
      end
    end
    checks++; if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_reached_full got=%b exp=1", saw_full); end
    checks++; if (saw_reopen !== 1'b1) begin errors++; $display("FAIL bp_reopened got=%b exp=1", saw_reopen); end
    for (int c = 0; c < 30; c++) begin
      tick(1'b0, 32'h0, 1'b0);
      if (retire === 1'b1) got.push_back(issue_inst);
    end
    checks++; if (got.size() != sent.size()) begin errors++; $display("FAIL bp_retired_count got=%0d exp=%0d", got.size(), sent.size()); end
    for (int i = 0; i < sent.size() && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL bp_order idx=%0d got=%h exp=%h", i, got[i], sent[i]); end
    end
  endtask

  task automatic test_flush();
    logic [1:0] ph [4];
    ph = '{2'b00, 2'b01, 2'b11, 2'b10};
    go_idle();
    tick(1'b1, 32'h0000_0101, 1'b0);
    tick(1'b1, 32'h0000_0204, 1'b0);
    tick(1'b1, 32'h0000_0305, 1'b0);
    tick(1'b1, 32'h0000_0408, 1'b0);
    checks++; if (phase !== 2'b11) begin errors++; $display("FAIL fl_pre_phase got=%b exp=11", phase); end
    checks++; if (fifo_count !== CW'(3)) begin errors++; $display("FAIL fl_pre_count got=%0d exp=3", fifo_count); end
    tick(1'b1, 32'h0000_0508, 1'b1);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fl_busy got=%b exp=0", busy); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL fl_count got=%0d exp=0", fifo_count); end
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL fl_retire got=%b exp=0", retire); end
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL fl_phase got=%b exp=00", phase); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fl_ready got=%b exp=1", in_ready); end
    tick(1'b1, 32'h0000_0637, 1'b0);
    checks++; if (retire !== 1'b0) begin errors++; $display("FAIL fl_post_retire got=%b exp=0", retire); end
    for (int c = 0; c < 4; c++) begin
      tick(1'b0, 32'h0, 1'b0);
      checks++; if (phase !== ph[c]) begin errors++; $display("FAIL fl_new_phase c=%0d got=%b exp=%b", c, phase, ph[c]); end
      checks++; if (retire !== (c == 3)) begin errors++; $display("FAIL fl_new_retire c=%0d got=%b exp=%b", c, retire, (c == 3)); end
      checks++; if (issue_inst !== 32'h637) begin errors++; $display("FAIL fl_new_issue c=%0d got=%h exp=637", c, issue_inst); end
    end
  endtask

  task automatic test_reset_mid();
    go_idle();
    tick(1'b1, 32'h0000_0108, 1'b0);
    tick(1'b1, 32'h0000_0201, 1'b0);
    tick(1'b1, 32'h0000_0302, 1'b0);
    checks++; if (phase !== 2'b01) begin errors++; $display("FAIL rm_pre_phase got=%b exp=01", phase); end
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got=%b exp=0", busy); end
    checks++; if (phase !== 2'b00) begin errors++; $display("FAIL rm_phase got=%b exp=00", phase); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL rm_count got=%0d exp=0", fifo_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(1'b0, 32'h0, 1'b0);
      checks++; if (retire !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rm_after c=%0d got retire=%b busy=%b exp=0/0", c, retire, busy); end
    end
  endtask

  task automatic test_random();
    logic        v;
    logic        f;
    logic [31:0] w;
    logic [2:0]  r;
    logic [2:0]  idx;
    for (int c = 0; c < 800; c++) begin
      v   = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 39) == 0);
      r   = 3'($urandom_range(0, 7));
      idx = 3'($urandom_range(0, 7));
      w   = $urandom;
      if (r < 3'd2)      w[6:0] = 7'h00;
      else if (r < 3'd6) w[6:0] = legal_ops[idx];
      tick(v, w, f);
      checks++; if (busy !== m_active) begin errors++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, m_active); end
      checks++; if (phase !== m_phase()) begin errors++; $display("FAIL rnd_phase c=%0d got=%b exp=%b", c, phase, m_phase()); end
      checks++; if (retire !== m_retire()) begin errors++; $display("FAIL rnd_retire c=%0d got=%b exp=%b", c, retire, m_retire()); end
      checks++; if (illegal !== m_illegal()) begin errors++; $display("FAIL rnd_illegal c=%0d got=%b exp=%b", c, illegal, m_illegal()); end
      checks++; if (fifo_count !== CW'(mq.size())) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, fifo_count, mq.size()); end
      checks++; if (in_ready !== (mq.size() != DEPTH)) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, (mq.size() != DEPTH)); end
      checks++; if (issue_inst !== m_word) begin errors++; $display("FAIL rnd_issue c=%0d got=%h exp=%h", c, issue_inst, m_word); end
    end
  endtask

  initial begin
    test_reset();
    test_four_cycle();
    test_back_to_back();
    test_nop_stream();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
